// File: rtl/poly_job_arbiter.sv
// Two-requester round-robin front end for a shared a*x^2 + b*x + c engine.
// One add/multiply step per cycle in Horner order: ((a*x)+b)*x + c.
module poly_job_arbiter #(
  parameter int unsigned WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [1:0]           req,
  input  logic [4*WIDTH-1:0]   operands0,
  input  logic [4*WIDTH-1:0]   operands1,
  output logic [1:0]           ack,
  output logic                 busy,
  output logic                 result_valid,
  output logic                 result_id,
  output logic [WIDTH-1:0]     result
);

  localparam int unsigned OPW = 4 * WIDTH;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_MUL1 = 3'd1,
    S_ADD1 = 3'd2,
    S_MUL2 = 3'd3,
    S_ADD2 = 3'd4
  } state_t;

  state_t             r_state;
  state_t             w_state_next;
  logic               w_grant;
  logic               w_grant_id;
  logic [OPW-1:0]     w_ops;

  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic [WIDTH-1:0]   r_c;
  logic [WIDTH-1:0]   r_x;
  logic [WIDTH-1:0]   r_t;
  logic               r_owner;
  logic               r_last_grant;
  logic [1:0]         r_ack;
  logic               r_busy;
  logic               r_result_valid;
  logic               r_result_id;
  logic [WIDTH-1:0]   r_result;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_next;
  end

  // Next state and round-robin grant decision
  always_comb begin
    w_state_next = r_state;
    w_grant      = 1'b0;
    w_grant_id   = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (req != 2'b00) begin
          w_grant      = 1'b1;
          w_state_next = S_MUL1;
          unique case (req)
            2'b01:   w_grant_id = 1'b0;
            2'b10:   w_grant_id = 1'b1;
            default: w_grant_id = ~r_last_grant;
          endcase
        end
      end
      S_MUL1:  w_state_next = S_ADD1;
      S_ADD1:  w_state_next = S_MUL2;
      S_MUL2:  w_state_next = S_ADD2;
      S_ADD2:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  assign w_ops = w_grant_id ? operands1 : operands0;

  // Operand latch, working register and registered handshakes
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_a            <= '0;
      r_b            <= '0;
      r_c            <= '0;
      r_x            <= '0;
      r_t            <= '0;
      r_owner        <= 1'b0;
      r_last_grant   <= 1'b1;
      r_ack          <= 2'b00;
      r_busy         <= 1'b0;
      r_result_valid <= 1'b0;
      r_result_id    <= 1'b0;
      r_result       <= '0;
    end else begin
      r_ack          <= w_grant ? (w_grant_id ? 2'b10 : 2'b01) : 2'b00;
      r_busy         <= (w_state_next != S_IDLE);
      r_result_valid <= (r_state == S_ADD2);
      if (w_grant) begin
        r_a          <= w_ops[3*WIDTH +: WIDTH];
        r_b          <= w_ops[2*WIDTH +: WIDTH];
        r_c          <= w_ops[1*WIDTH +: WIDTH];
        r_x          <= w_ops[0     +: WIDTH];
        r_owner      <= w_grant_id;
        r_last_grant <= w_grant_id;
      end
      unique case (r_state)
        S_MUL1: r_t <= WIDTH'(r_a * r_x);
        S_ADD1: r_t <= WIDTH'(r_t + r_b);
        S_MUL2: r_t <= WIDTH'(r_t * r_x);
        S_ADD2: begin
          r_result    <= WIDTH'(r_t + r_c);
          r_result_id <= r_owner;
        end
        default: r_t <= r_t;
      endcase
    end
  end

  assign ack          = r_ack;
  assign busy         = r_busy;
  assign result_valid = r_result_valid;
  assign result_id    = r_result_id;
  assign result       = r_result;

endmodule

// File: tb/tb_poly_job_arbiter.sv
// Directed bench for poly_job_arbiter: vector table of single jobs plus
// hand sequences for fairness, operand stability, mid-job reset and idle hold.
module tb_poly_job_arbiter;

  localparam int unsigned W = 8;

  logic           clk;
  logic           reset;
  logic [1:0]     req;
  logic [4*W-1:0] operands0;
  logic [4*W-1:0] operands1;
  logic [1:0]     ack;
  logic           busy;
  logic           result_valid;
  logic           result_id;
  logic [W-1:0]   result;

  int n_cmp;
  int n_bad;

  poly_job_arbiter #(.WIDTH(W)) dut (
    .clk          (clk),
    .reset        (reset),
    .req          (req),
    .operands0    (operands0),
    .operands1    (operands1),
    .ack          (ack),
    .busy         (busy),
    .result_valid (result_valid),
    .result_id    (result_id),
    .result       (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]     req;
    logic [4*W-1:0] op0;
    logic [4*W-1:0] op1;
    logic [1:0]     exp_ack;
    logic [W-1:0]   exp_res;
    logic           exp_id;
  } vec_t;

  vec_t vecs[7];

  function automatic logic [4*W-1:0] pk(input int a, input int b, input int c, input int x);
    pk = {W'(a), W'(b), W'(c), W'(x)};
  endfunction

  task automatic check(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Starts and ends on a negedge with the DUT idle
  task automatic do_job(input string nm, input logic [1:0] rq, input logic [4*W-1:0] o0,
                        input logic [4*W-1:0] o1, input logic [1:0] eack,
                        input logic [W-1:0] eres, input logic eid);
    int k;
    req = rq; operands0 = o0; operands1 = o1;
    @(posedge clk); @(negedge clk);
    check($sformatf("%s_ack", nm), int'(ack), int'(eack));
    check($sformatf("%s_busy", nm), int'(busy), 1);
    req = 2'b00;
    k = 1;
    while (!result_valid && k < 12) begin
      @(negedge clk);
      k++;
    end
    check($sformatf("%s_latency", nm), k - 1, 4);
    check($sformatf("%s_result", nm), int'(result), int'(eres));
    check($sformatf("%s_id", nm), int'(result_id), int'(eid));
    check($sformatf("%s_busy_end", nm), int'(busy), 0);
    @(negedge clk);
    check($sformatf("%s_rv_pulse", nm), int'(result_valid), 0);
  endtask

  initial begin
    int pulses;
    int prev_rv;
    int busy_cnt;
    logic [1:0] exp_ack;

    n_cmp = 0; n_bad = 0;
    reset = 1'b1; req = 2'b00; operands0 = '0; operands1 = '0;

    vecs[0] = '{2'b01, pk(2, 3, 4, 5),         pk(0, 0, 0, 0),  2'b01, 8'd69,  1'b0};
    vecs[1] = '{2'b10, pk(0, 0, 0, 0),         pk(16, 0, 1, 16), 2'b10, 8'd1,   1'b1};
    vecs[2] = '{2'b01, pk(255, 255, 255, 255), pk(0, 0, 0, 0),  2'b01, 8'd255, 1'b0};
    vecs[3] = '{2'b10, pk(9, 9, 9, 9),         pk(3, 7, 11, 2), 2'b10, 8'd37,  1'b1};
    vecs[4] = '{2'b11, pk(1, 1, 1, 2),         pk(0, 0, 9, 7),  2'b01, 8'd7,   1'b0};
    vecs[5] = '{2'b11, pk(1, 1, 1, 2),         pk(0, 0, 9, 7),  2'b10, 8'd9,   1'b1};
    vecs[6] = '{2'b01, pk(0, 0, 0, 0),         pk(5, 5, 5, 5),  2'b01, 8'd0,   1'b0};

    // Reset values
    @(negedge clk);
    check("rst_ack", int'(ack), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_rv", int'(result_valid), 0);
    check("rst_result", int'(result), 0);
    check("rst_id", int'(result_id), 0);
    reset = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 7; i++)
      do_job($sformatf("vec%0d", i), vecs[i].req, vecs[i].op0, vecs[i].op1,
             vecs[i].exp_ack, vecs[i].exp_res, vecs[i].exp_id);

    // Both requesters held after reset: alternating grants, one result per 5 cycles
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    req = 2'b11; operands0 = pk(1, 1, 1, 2); operands1 = pk(0, 0, 9, 7);
    pulses = 0; prev_rv = -1; exp_ack = 2'b01;
    for (int cyc = 1; cyc <= 25; cyc++) begin
      @(negedge clk);
      if (ack != 2'b00) begin
        check($sformatf("rr_ack_c%0d", cyc), int'(ack), int'(exp_ack));
        exp_ack = ~exp_ack;
      end
      if (result_valid) begin
        check($sformatf("rr_res_c%0d", cyc), int'(result), (pulses % 2 == 0) ? 7 : 9);
        check($sformatf("rr_id_c%0d", cyc), int'(result_id), pulses % 2);
        if (prev_rv >= 0) check($sformatf("rr_period_c%0d", cyc), cyc - prev_rv, 5);
        prev_rv = cyc;
        pulses++;
      end
    end
    check("rr_pulses", pulses, 5);
    req = 2'b00;
    repeat (6) @(negedge clk);

    // Operand change after grant must not disturb the job
    req = 2'b01; operands0 = pk(2, 3, 4, 5);
    @(posedge clk); @(negedge clk);
    operands0 = pk(9, 9, 9, 9); req = 2'b00;
    busy_cnt = 0;
    for (int cyc = 0; cyc < 10 && !result_valid; cyc++) begin
      if (busy) busy_cnt++;
      @(negedge clk);
    end
    check("stab_busy_cycles", busy_cnt, 4);
    check("stab_rv", int'(result_valid), 1);
    check("stab_result", int'(result), 69);
    @(negedge clk);

    // Asynchronous reset during MUL2
    req = 2'b01; operands0 = pk(2, 3, 4, 5);
    @(posedge clk); @(negedge clk);
    req = 2'b00;
    @(negedge clk);
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("arst_busy", int'(busy), 0);
    check("arst_result", int'(result), 0);
    check("arst_rv", int'(result_valid), 0);
    check("arst_ack", int'(ack), 0);
    @(negedge clk);
    reset = 1'b0;
    for (int cyc = 0; cyc < 3; cyc++) begin
      @(negedge clk);
      check($sformatf("arst_no_rv%0d", cyc), int'(result_valid), 0);
    end
    do_job("arst_rr", 2'b11, pk(2, 3, 4, 5), pk(0, 0, 9, 7), 2'b01, 8'd69, 1'b0);

    // Idle hold with no requests
    req = 2'b00;
    for (int cyc = 0; cyc < 20; cyc++) begin
      @(negedge clk);
      check($sformatf("idle_result%0d", cyc), int'(result), 69);
      check($sformatf("idle_rv%0d", cyc), int'(result_valid), 0);
      check($sformatf("idle_busy%0d", cyc), int'(busy), 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
